pipe_if_fetch: RTL and testbench

// Instruction-fetch stage with a built-in IF/ID latch, feeding the decode stage (dpc4, inst) and consuming
// its redirect outputs (pcsource, bpc, jpc, a, nostall). It decouples a variable-latency instruction memory

---
 rtl/pipe_if_fetch.sv | 143 ++++++++++++++
 tb/tb_pipe_if_fetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_if_fetch.sv
// Instruction-fetch stage with IF/ID latch: 2-entry prefetch FIFO in front of a
// variable-latency instruction memory, with single branch-delay-slot redirect handling.
module pipe_if_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] ra,
  input  logic        nostall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  typedef enum logic [1:0] {IDLE, REQ, KILL} state_t;

  state_t      state, state_n;
  logic [31:0] fpc, fpc_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] tgt, tgt_n;
  logic        tgt_pend, tgt_pend_n;
  logic [31:0] q_pc4  [FIFO_DEPTH];
  logic [31:0] q_inst [FIFO_DEPTH];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count, count_n;
  logic [31:0] target;
  logic        redirect, ack_ok, flush, take, pop, bypass, push;

  always_comb begin
    case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = ra;
      2'b11:   target = jpc;
      default: target = fpc;
    endcase
  end

  assign redirect = nostall && dvalid && (pcsource != 2'b00);
  assign ack_ok   = imem_ack && (state == REQ);
  // A redirect with buffered work keeps only the FIFO head (the delay slot)
  assign flush    = redirect && (count != 2'd0);
  assign take     = ack_ok && !flush;
  assign pop      = nostall && (count != 2'd0);
  assign bypass   = nostall && (count == 2'd0) && take;
  assign push     = take && !bypass;

  always_comb begin
    if (flush) count_n = 2'd0;
    else       count_n = count - {1'b0, pop} + {1'b0, push};
  end

  always_comb begin
    state_n    = state;
    fpc_n      = fpc;
    tgt_n      = tgt;
    tgt_pend_n = tgt_pend;
    if (take) fpc_n = tgt_pend ? tgt : fpc + 32'd4;
    if (ack_ok && tgt_pend) tgt_pend_n = 1'b0;
    // Slot already resolved (in FIFO or arriving now): redirect at once; else defer to slot ack
    if (redirect) begin
      if (flush || ack_ok) begin
        fpc_n = target;
      end else begin
        tgt_pend_n = 1'b1;
        tgt_n      = target;
      end
    end
    case (state)
      IDLE:    if (count_n < 2'd2) state_n = REQ;
      REQ: begin
        if (imem_ack)   state_n = (count_n < 2'd2) ? REQ : IDLE;
        else if (flush) state_n = KILL;
      end
      KILL:    if (imem_ack) state_n = (count_n < 2'd2) ? REQ : IDLE;
      default: state_n = IDLE;
    endcase
    // The outstanding address stays stable until acked, even when being killed
    addr_n = ((state != IDLE) && !imem_ack) ? addr_q : fpc_n;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      fpc      <= RESET_PC;
      addr_q   <= RESET_PC;
      tgt      <= '0;
      tgt_pend <= 1'b0;
      count    <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      dpc4     <= '0;
      inst     <= '0;
      dvalid   <= 1'b0;
    end else begin
      state    <= state_n;
      fpc      <= fpc_n;
      addr_q   <= addr_n;
      tgt      <= tgt_n;
      tgt_pend <= tgt_pend_n;
      count    <= count_n;
      if (flush) begin
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (pop)  rd_ptr <= ~rd_ptr;
        if (push) wr_ptr <= ~wr_ptr;
      end
      if (nostall) begin
        if (count != 2'd0) begin
          dpc4   <= q_pc4[rd_ptr];
          inst   <= q_inst[rd_ptr];
          dvalid <= 1'b1;
        end else if (take) begin
          dpc4   <= addr_q + 32'd4;
          inst   <= imem_rdata;
          dvalid <= 1'b1;
        end else begin
          inst   <= '0;
          dvalid <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc4[wr_ptr]  <= addr_q + 32'd4;
      q_inst[wr_ptr] <= imem_rdata;
    end
  end

  assign imem_req  = (state != IDLE);
  assign imem_addr = addr_q;

endmodule

// File: tb/tb_pipe_if_fetch.sv
// Directed bench for pipe_if_fetch: per-cycle vector table for streaming/stall,
// plus hand-written redirect and reset-mid-request sequences against a latency model.
module tb_pipe_if_fetch;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [1:0]  pcsource = 2'b00;
  logic [31:0] bpc = '0, jpc = '0, ra = '0;
  logic        nostall = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] dpc4, inst;
  logic        dvalid;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  logic stray_ack = 1'b0;
  logic [31:0] inst_q[$];
  logic [31:0] ack_q[$];

  pipe_if_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .clr(clr), .pcsource(pcsource), .bpc(bpc), .jpc(jpc), .ra(ra),
    .nostall(nostall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dpc4(dpc4), .inst(inst), .dvalid(dvalid)
  );

  always #5 clk = ~clk;

  // Memory model: first ack 'lat' cycles after req rises, then acks 'lat' cycles apart; data = address
  initial begin
    int  w = 0;
    logic req_prev = 1'b0, ack_prev = 1'b0, mack;
    forever begin
      @(posedge clk); #1;
      mack = 1'b0;
      if (imem_req) begin
        if (ack_prev)      w = 1;
        else if (!req_prev) w = 0;
        else               w = w + 1;
        mack = (w >= lat);
      end
      req_prev   = imem_req;
      ack_prev   = mack;
      imem_ack   = mack | stray_ack;
      imem_rdata = stray_ack ? 32'hDEAD_BEEF : imem_addr;
      if (mack) ack_q.push_back(imem_addr);
    end
  end

  // Record every instruction loaded into the IF/ID latch
  initial begin
    logic ns_seen;
    forever begin
      @(posedge clk);
      ns_seen = nostall;
      @(negedge clk);
      if (ns_seen && dvalid) inst_q.push_back(inst);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_req"},  32'(imem_req), 32'd0);
    check({nm, "_addr"}, imem_addr, 32'h0);
    check({nm, "_dpc4"}, dpc4, 32'h0);
    check({nm, "_inst"}, inst, 32'h0);
    check({nm, "_dv"},   32'(dvalid), 32'd0);
  endtask

  task automatic do_reset(input int l, input string nm);
    @(negedge clk);
    clr = 1'b1; lat = l; nostall = 1'b1; pcsource = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check_reset(nm);
    inst_q.delete();
    ack_q.delete();
    clr = 1'b0;
  endtask

  task automatic wait_inst(input logic [31:0] v, input string nm);
    int unsigned n = 0;
    logic found;
    do begin
      @(posedge clk); #1;
      n++;
      found = dvalid && (inst == v);
    end while (!found && n < 300);
    check(nm, 32'(found), 32'd1);
  endtask

  task automatic check_q(input string nm, input logic [31:0] got[$], input logic [31:0] exp[$]);
    check({nm, "_len"}, 32'(got.size() >= exp.size()), 32'd1);
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      check($sformatf("%s[%0d]", nm, i), got[i], exp[i]);
  endtask

  typedef struct {
    logic        ns;
    logic        req;
    logic [31:0] addr;
    logic        dv;
    logic [31:0] inst;
    logic [31:0] dpc4;
  } vec_t;

  initial begin
    vec_t vt[13];
    logic [31:0] exp_i[$];
    logic [31:0] exp_a[$];

    // Cycles after reset release, latency-1 memory; 5-cycle stall fills FIFO then drains
    vt[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00};
    vt[1]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 32'h00};
    vt[2]  = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h00, 32'h04};
    vt[3]  = '{1'b0, 1'b1, 32'h08, 1'b1, 32'h04, 32'h08};
    vt[4]  = '{1'b0, 1'b1, 32'h0C, 1'b1, 32'h04, 32'h08};
    vt[5]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h04, 32'h08};
    vt[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h04, 32'h08};
    vt[7]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h04, 32'h08};
    vt[8]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h04, 32'h08};
    vt[9]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 32'h0C};
    vt[10] = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h0C, 32'h10};
    vt[11] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h10, 32'h14};
    vt[12] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h14, 32'h18};

    do_reset(1, "rst0");
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      nostall = vt[i].ns;
      @(negedge clk);
      check($sformatf("c%0d_req", i + 1),  32'(imem_req), 32'(vt[i].req));
      check($sformatf("c%0d_addr", i + 1), imem_addr, vt[i].addr);
      check($sformatf("c%0d_dv", i + 1),   32'(dvalid), 32'(vt[i].dv));
      check($sformatf("c%0d_inst", i + 1), inst, vt[i].inst);
      check($sformatf("c%0d_dpc4", i + 1), dpc4, vt[i].dpc4);
    end

    // Branch with FIFO holding {0x14,0x18}: 0x14 kept as slot, 0x18 flushed
    do_reset(1, "rstA");
    wait_inst(32'h10, "A_wait10");
    nostall = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("A_full_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    nostall = 1'b1; pcsource = 2'b01; bpc = 32'h100;
    check("A_hold_inst", inst, 32'h10);
    check("A_hold_dpc4", dpc4, 32'h14);
    @(posedge clk); #1;
    pcsource = 2'b00;
    check("A_req", 32'(imem_req), 32'd1);
    check("A_addr", imem_addr, 32'h100);
    check("A_slot", inst, 32'h14);
    check("A_slot_dpc4", dpc4, 32'h18);
    wait_inst(32'h104, "A_wait104");
    @(negedge clk); #1;
    exp_i = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h100, 32'h104};
    exp_a = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18, 32'h100, 32'h104};
    check_q("A_inst", inst_q, exp_i);
    check_q("A_ack", ack_q, exp_a);

    // Same branch, FIFO empty, latency 4: in-flight 0x14 is the slot, 0x18 never fetched
    do_reset(4, "rstB");
    wait_inst(32'h10, "B_wait10");
    pcsource = 2'b01; bpc = 32'h100;
    @(posedge clk); #1;
    pcsource = 2'b00;
    check("B_bubble", 32'(dvalid), 32'd0);
    wait_inst(32'h14, "B_wait14");
    check("B_addr", imem_addr, 32'h100);
    check("B_req", 32'(imem_req), 32'd1);
    wait_inst(32'h104, "B_wait104");
    @(negedge clk); #1;
    exp_i = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h100, 32'h104};
    check_q("B_inst", inst_q, exp_i);
    check_q("B_ack", ack_q, exp_i);

    // jr (ra) then jal (jpc), slot response arrives in the redirect cycle
    do_reset(1, "rstC");
    wait_inst(32'h8, "C_wait8");
    pcsource = 2'b10; ra = 32'h2000;
    @(posedge clk); #1;
    pcsource = 2'b00;
    check("C_jr_addr", imem_addr, 32'h2000);
    check("C_jr_slot", inst, 32'hC);
    wait_inst(32'h2004, "C_wait2004");
    pcsource = 2'b11; jpc = 32'h0040_0000;
    @(posedge clk); #1;
    pcsource = 2'b00;
    check("C_jal_addr", imem_addr, 32'h0040_0000);
    check("C_jal_slot", inst, 32'h2008);
    wait_inst(32'h0040_0004, "C_wait400004");
    @(negedge clk); #1;
    exp_i = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h2000, 32'h2004, 32'h2008,
              32'h0040_0000, 32'h0040_0004};
    check_q("C_inst", inst_q, exp_i);
    check_q("C_ack", ack_q, exp_i);

    // Reset while a request awaits its ack; a stray ack right after must be ignored
    do_reset(4, "rstD");
    @(posedge clk); #1;
    check("D_req_up", 32'(imem_req), 32'd1);
    @(posedge clk); #2;
    clr = 1'b1;
    @(negedge clk);
    check_reset("D_midreq");
    stray_ack = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    @(negedge clk);
    stray_ack = 1'b0;
    check("D_stray_req", 32'(imem_req), 32'd0);
    check("D_stray_dv", 32'(dvalid), 32'd0);
    @(negedge clk);
    check("D_restart_req", 32'(imem_req), 32'd1);
    check("D_restart_addr", imem_addr, 32'h0);
    begin
      int unsigned n = 0;
      while (!dvalid && n < 50) begin
        @(negedge clk);
        n++;
      end
    end
    check("D_first_dv", 32'(dvalid), 32'd1);
    check("D_first_inst", inst, 32'h0);
    check("D_first_dpc4", dpc4, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
